// File: rtl/nibble_serial_adder_if.sv
// Operand/result bundle for the nibble-serial adder: an operand handshake in
// and a result handshake out, both with the same valid/ready rules.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  // valid/ready: a transfer happens on a rising clk edge where both are high;
  // the sender holds its data stable while valid is high and ready is low, and
  // neither ready nor valid depends combinationally on the other side.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, sum, co
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, sum, co
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that walks the operands one nibble per clock through a single
// 4-bit carry-lookahead slice, carrying between nibbles in a register.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  nibble_serial_adder_if.slave bus,
  output logic [1:0]          state_o
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q;
  logic             co_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;

  logic [3:0] a_nib, b_nib, p, g, s_nib;
  logic [4:0] c;

  // Lookahead carries for the current nibble, seeded by the registered carry.
  always_comb begin
    a_nib = a_q[{idx_q, 2'b00} +: 4];
    b_nib = b_q[{idx_q, 2'b00} +: 4];
    p     = a_nib ^ b_nib;
    g     = a_nib & b_nib;
    c[0]  = carry_q;
    c[1]  = g[0] | (p[0] & c[0]);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s_nib = p ^ c[3:0];
    work_d = work_q;
    work_d[{idx_q, 2'b00} +: 4] = s_nib;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.ci;
            idx_q   <= '0;
            state_q <= ADD;
          end
        end
        ADD: begin
          work_q  <= work_d;
          carry_q <= c[4];
          if (idx_q == IW'(N - 1)) begin
            sum_q   <= work_d;
            co_q    <= c[4];
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.co        = co_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH=16: vector table plus
// hand-written backpressure and mid-operation reset sequences.
module tb_nibble_serial_adder;
  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_o;
  int         errors;
  int         checks;

  nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_co;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one operation from IDLE and collect it, checking latency and result.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic [WIDTH-1:0] exp_sum,
                        input logic exp_co);
    int budget;
    budget = 20;
    while (!bus.in_ready && budget > 0) begin
      @(posedge clk); #1; budget--;
    end
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.a = a; bus.b = b; bus.ci = ci; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = ~a; bus.b = ~b; bus.ci = ~ci;
    check("in_ready_during_add", 32'(bus.in_ready), 32'd0);
    for (int k = 1; k <= N; k++) begin
      @(posedge clk); #1;
      if (k < N) begin
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
          check("early_out_valid_or_in_ready", {30'd0, bus.out_valid, bus.in_ready}, 32'd0);
        end
      end
    end
    check("out_valid_latency", 32'(bus.out_valid), 32'd1);
    check("sum", 32'(bus.sum), 32'(exp_sum));
    check("co", 32'(bus.co), 32'(exp_co));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid_after_handoff", 32'(bus.out_valid), 32'd0);
    check("in_ready_after_handoff", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.ci        = 1'b0;
    bus.out_ready = 1'b0;

    vecs.push_back('{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0});
    vecs.push_back('{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0});
    vecs.push_back('{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0FF0, 16'h0010, 1'b1, 16'h1001, 1'b0});

    // reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sum", 32'(bus.sum), 32'h0);
    check("rst_co", 32'(bus.co), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].exp_sum, vecs[i].exp_co);
    end

    // backpressure: result held, new operands ignored
    bus.a = 16'h1234; bus.b = 16'h4321; bus.ci = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (N) @(posedge clk);
    #1;
    bus.a = 16'h0003; bus.b = 16'h0004; bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_sum", 32'(bus.sum), 32'h5555);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_sum_kept_in_idle", 32'(bus.sum), 32'h5555);
    run_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);

    // reset mid-ADD, asserted between clock edges
    bus.a = 16'h00FF; bus.b = 16'h0001; bus.ci = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_sum_async", 32'(bus.sum), 32'h0);
    check("midrst_co_async", 32'(bus.co), 32'd0);
    check("midrst_in_ready_async", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) check("midrst_no_result", 32'(bus.out_valid), 32'd0);
    end
    check("midrst_sum_after", 32'(bus.sum), 32'h0);
    run_op(16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
